// File: rtl/instruction_issue_unit.sv
// ---------------------------------------------------------------------------
// instruction_issue_unit
//
// Holds a small program memory filled word by word by a loader. On start_in
// it walks the memory from address 0 and presents each nonzero word on
// current_instruction for ISSUE_CYCLES non-stalled cycles, with one FETCH
// cycle (valid low) between words. An all-zero word or the last address
// ends the run in DONE.
//
// Parameters:
//   DEPTH        program memory words (power of two, >= 2)
//   INSTR_WIDTH  instruction width in bits
//   ISSUE_CYCLES non-stalled cycles each instruction is held (>= 1)
//
// Ports:
//   clock_in            single clock, rising edge
//   reset_n_in          asynchronous active-low reset
//   load_valid_in       write load_data_in to load_addr_in (IDLE/DONE only)
//   load_addr_in        program memory write address
//   load_data_in        program word
//   start_in            begin execution from address 0 (IDLE/DONE only)
//   stall_in            freezes the issue countdown and all outputs
//   current_instruction instruction to the CPU, 0 when not valid
//   instruction_valid   current_instruction holds a real program word
//   pc_out              address of the word being fetched or issued
//   busy_out            state is FETCH or ISSUE
//   done_out            program finished; held until the next start
// ---------------------------------------------------------------------------
module instruction_issue_unit #(
  parameter int DEPTH        = 64,
  parameter int INSTR_WIDTH  = 32,
  parameter int ISSUE_CYCLES = 3,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                   clock_in,
  input  logic                   reset_n_in,
  input  logic                   load_valid_in,
  input  logic [AW-1:0]          load_addr_in,
  input  logic [INSTR_WIDTH-1:0] load_data_in,
  input  logic                   start_in,
  input  logic                   stall_in,
  output logic [INSTR_WIDTH-1:0] current_instruction,
  output logic                   instruction_valid,
  output logic [AW-1:0]          pc_out,
  output logic                   busy_out,
  output logic                   done_out
);

  localparam int CW = $clog2(ISSUE_CYCLES + 1);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(ISSUE_CYCLES);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
  localparam logic [AW-1:0] LAST_PC    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [AW-1:0]          pc_reg, pc_next;
  logic [CW-1:0]          count_reg, count_next;
  logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
  logic                   valid_reg, valid_next;
  logic                   busy_reg, busy_next;
  logic                   done_reg, done_next;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] fetch_word;
  logic                   load_enable;

  // Loads are only honoured while no program is running, so a running
  // sequence can never be disturbed by the loader.
  assign load_enable = load_valid_in && ((state_reg == IDLE) || (state_reg == DONE));

  // Program memory survives reset, so it has no reset branch.
  always_ff @(posedge clock_in) begin
    if (load_enable) begin
      mem[load_addr_in] <= load_data_in;
    end
  end

  // Combinational read: a load and start on the same edge lets FETCH see
  // the freshly written word in the following cycle.
  assign fetch_word = mem[pc_reg];

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      count_reg <= '0;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      count_reg <= count_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    done_next  = done_reg;

    case (state_reg)
      IDLE: begin
        if (start_in) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end

      FETCH: begin
        if (fetch_word == '0) begin
          // Halt word: finish without issuing anything.
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          instr_next = fetch_word;
          valid_next = 1'b1;
          count_next = COUNT_LOAD;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        if (!stall_in) begin
          // The edge that takes the countdown from 1 to 0 ends the hold.
          if (count_reg <= COUNT_ONE) begin
            count_next = '0;
            instr_next = '0;
            valid_next = 1'b0;
            if (pc_reg == LAST_PC) begin
              // End of memory: never wrap, terminate here.
              done_next  = 1'b1;
              state_next = DONE;
            end else begin
              pc_next    = pc_reg + AW'(1);
              state_next = FETCH;
            end
          end else begin
            count_next = count_reg - COUNT_ONE;
          end
        end
      end

      DONE: begin
        if (start_in) begin
          done_next  = 1'b0;
          pc_next    = '0;
          state_next = FETCH;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Busy is registered from the next state so it lines up with state_reg.
    busy_next = (state_next == FETCH) || (state_next == ISSUE);
  end

  assign current_instruction = instr_reg;
  assign instruction_valid   = valid_reg;
  assign pc_out              = pc_reg;
  assign busy_out            = busy_reg;
  assign done_out            = done_reg;

endmodule

// File: tb/tb_instruction_issue_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_issue_unit
//
// Directed bench for instruction_issue_unit with default parameters
// (DEPTH=64, INSTR_WIDTH=32, ISSUE_CYCLES=3). Inputs change and outputs are
// sampled 1 ns after the rising clock edge. Cycle index k counts rising
// edges after the edge that sampled start_in.
// ---------------------------------------------------------------------------
module tb_instruction_issue_unit;

  logic        clock_in;
  logic        reset_n_in;
  logic        load_valid_in;
  logic [5:0]  load_addr_in;
  logic [31:0] load_data_in;
  logic        start_in;
  logic        stall_in;
  logic [31:0] current_instruction;
  logic        instruction_valid;
  logic [5:0]  pc_out;
  logic        busy_out;
  logic        done_out;

  int vectors;
  int miscompares;

  instruction_issue_unit dut (
    .clock_in            (clock_in),
    .reset_n_in          (reset_n_in),
    .load_valid_in       (load_valid_in),
    .load_addr_in        (load_addr_in),
    .load_data_in        (load_data_in),
    .start_in            (start_in),
    .stall_in            (stall_in),
    .current_instruction (current_instruction),
    .instruction_valid   (instruction_valid),
    .pc_out              (pc_out),
    .busy_out            (busy_out),
    .done_out            (done_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_load(input logic [5:0] addr, input logic [31:0] data);
    load_valid_in = 1'b1;
    load_addr_in  = addr;
    load_data_in  = data;
    step();
    load_valid_in = 1'b0;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    step();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (done_out === 1'b1) break;
      step();
    end
    vectors++;
    if (done_out !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: done_out=%b after %0d cycles, expected 1", name, done_out, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset_n_in    = 1'b0;
    load_valid_in = 1'b0;
    load_addr_in  = '0;
    load_data_in  = '0;
    start_in      = 1'b0;
    stall_in      = 1'b0;
    repeat (3) step();
    #2 reset_n_in = 1'b1;
    step();
    vectors++;
    if ({current_instruction, instruction_valid, pc_out, busy_out, done_out} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset: instr=%h valid=%b pc=%0d busy=%b done=%b, expected all 0",
               current_instruction, instruction_valid, pc_out, busy_out, done_out);
    end
  endtask

  // Program 0x11111111, 0x22222222, 0: first word k=1..3, gap k=4,
  // second word k=5..7, FETCH of zero word k=8, DONE at k=9 with pc=2.
  task automatic check_basic_cycle(input string name, input int k);
    logic [31:0] exp_i;
    logic        exp_v, exp_b, exp_d;
    logic [5:0]  exp_pc;
    exp_v  = (k >= 1 && k <= 3) || (k >= 5 && k <= 7);
    exp_i  = (k <= 3) ? 32'h11111111 : (k >= 5 && k <= 7) ? 32'h22222222 : 32'h0;
    exp_pc = (k <= 3) ? 6'd0 : (k <= 7) ? 6'd1 : 6'd2;
    exp_d  = (k == 9);
    exp_b  = (k < 9);
    vectors++;
    if ({current_instruction, instruction_valid, pc_out, busy_out, done_out} !==
        {exp_i, exp_v, exp_pc, exp_b, exp_d}) begin
      miscompares++;
      $display("FAIL %s k=%0d: instr=%h valid=%b pc=%0d busy=%b done=%b, expected instr=%h valid=%b pc=%0d busy=%b done=%b",
               name, k, current_instruction, instruction_valid, pc_out, busy_out, done_out,
               exp_i, exp_v, exp_pc, exp_b, exp_d);
    end
  endtask

  task automatic test_basic();
    do_load(6'd0, 32'h11111111);
    do_load(6'd1, 32'h22222222);
    do_load(6'd2, 32'h00000000);
    vectors++;
    if ({instruction_valid, busy_out, done_out} !== 3'b000) begin
      miscompares++;
      $display("FAIL basic_idle_load: valid=%b busy=%b done=%b, expected 0 0 0",
               instruction_valid, busy_out, done_out);
    end
    pulse_start();
    vectors++;
    if ({instruction_valid, busy_out, done_out, pc_out} !== {3'b010, 6'd0}) begin
      miscompares++;
      $display("FAIL basic_fetch: valid=%b busy=%b done=%b pc=%0d, expected 0 1 0 0",
               instruction_valid, busy_out, done_out, pc_out);
    end
    for (int k = 1; k <= 9; k++) begin
      step();
      check_basic_cycle("basic", k);
    end
  endtask

  // Stall at edges 2..5 stretches the first word to 7 valid cycles.
  task automatic test_stall();
    logic        exp_v;
    logic [31:0] exp_i;
    logic [5:0]  exp_pc;
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      stall_in = (k >= 2 && k <= 5);
      step();
      exp_v  = (k <= 7);
      exp_i  = exp_v ? 32'h11111111 : 32'h0;
      exp_pc = (k <= 7) ? 6'd0 : 6'd1;
      vectors++;
      if ({current_instruction, instruction_valid, pc_out, done_out} !== {exp_i, exp_v, exp_pc, 1'b0}) begin
        miscompares++;
        $display("FAIL stall k=%0d: instr=%h valid=%b pc=%0d done=%b, expected instr=%h valid=%b pc=%0d done=0",
                 k, current_instruction, instruction_valid, pc_out, done_out, exp_i, exp_v, exp_pc);
      end
    end
    stall_in = 1'b0;
    wait_done("stall_done", 20);
    vectors++;
    if (pc_out !== 6'd2) begin
      miscompares++;
      $display("FAIL stall_pc: pc=%0d, expected 2", pc_out);
    end
  endtask

  // Load and start during ISSUE must not change anything.
  task automatic test_busy_protection();
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) begin
        load_valid_in = 1'b1;
        load_addr_in  = 6'd1;
        load_data_in  = 32'hDEADBEEF;
        start_in      = 1'b1;
      end else begin
        load_valid_in = 1'b0;
        start_in      = 1'b0;
      end
      step();
      check_basic_cycle("busy_protect", k);
    end
    load_valid_in = 1'b0;
    start_in      = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    step();
    step();
    #2 reset_n_in = 1'b0;
    #1;
    vectors++;
    if ({current_instruction, instruction_valid, pc_out, busy_out, done_out} !== 41'd0) begin
      miscompares++;
      $display("FAIL reset_mid: instr=%h valid=%b pc=%0d busy=%b done=%b, expected all 0",
               current_instruction, instruction_valid, pc_out, busy_out, done_out);
    end
    #1 reset_n_in = 1'b1;
    step();
    pulse_start();
    for (int k = 1; k <= 9; k++) begin
      step();
      check_basic_cycle("rerun", k);
    end
  endtask

  // From DONE: load address 0 and start on the same edge; FETCH must see
  // the new word and it is valid after the next edge.
  task automatic test_restart();
    vectors++;
    if (done_out !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_pre: done=%b, expected 1", done_out);
    end
    load_valid_in = 1'b1;
    load_addr_in  = 6'd0;
    load_data_in  = 32'h33333333;
    start_in      = 1'b1;
    step();
    load_valid_in = 1'b0;
    start_in      = 1'b0;
    vectors++;
    if ({done_out, busy_out, instruction_valid, pc_out} !== {3'b010, 6'd0}) begin
      miscompares++;
      $display("FAIL restart_fetch: done=%b busy=%b valid=%b pc=%0d, expected 0 1 0 0",
               done_out, busy_out, instruction_valid, pc_out);
    end
    step();
    vectors++;
    if ({current_instruction, instruction_valid} !== {32'h33333333, 1'b1}) begin
      miscompares++;
      $display("FAIL restart_issue: instr=%h valid=%b, expected 33333333 1",
               current_instruction, instruction_valid);
    end
    wait_done("restart_done", 20);
    vectors++;
    if (pc_out !== 6'd2) begin
      miscompares++;
      $display("FAIL restart_pc: pc=%0d, expected 2", pc_out);
    end
  endtask

  // Word j (value j+1) valid at k=4j+1..4j+3; the last word drops at k=256
  // straight into DONE with pc=63.
  task automatic test_full_memory();
    int          j, r;
    logic        exp_v, exp_d;
    logic [31:0] exp_i;
    logic [5:0]  exp_pc;
    for (int a = 0; a < 64; a++) begin
      do_load(6'(a), 32'(a + 1));
    end
    pulse_start();
    for (int k = 1; k <= 256; k++) begin
      step();
      j      = (k - 1) / 4;
      r      = (k - 1) % 4;
      exp_v  = (r < 3);
      exp_i  = exp_v ? 32'(j + 1) : 32'h0;
      exp_pc = (r == 3 && j < 63) ? 6'(j + 1) : 6'(j);
      exp_d  = (k == 256);
      vectors++;
      if ({current_instruction, instruction_valid, pc_out, done_out} !== {exp_i, exp_v, exp_pc, exp_d}) begin
        miscompares++;
        $display("FAIL full k=%0d: instr=%h valid=%b pc=%0d done=%b, expected instr=%h valid=%b pc=%0d done=%b",
                 k, current_instruction, instruction_valid, pc_out, done_out, exp_i, exp_v, exp_pc, exp_d);
      end
    end
    step();
    vectors++;
    if ({done_out, busy_out, instruction_valid, pc_out} !== {3'b100, 6'd63}) begin
      miscompares++;
      $display("FAIL full_hold: done=%b busy=%b valid=%b pc=%0d, expected 1 0 0 63",
               done_out, busy_out, instruction_valid, pc_out);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_stall();
    test_busy_protection();
    test_reset_mid_run();
    test_restart();
    test_full_memory();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
